// File: rtl/adder_rr_arbiter.sv
// Round-robin front end that shares one pipelined adder between NUM_REQ requesters.
// A {valid, index} tag pipeline matched to the adder latency steers each result back.
module adder_rr_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REQ     = 4,
  parameter int ADD_LATENCY = 2,
  localparam int PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         adder_a,
  output logic [DATA_WIDTH-1:0]         adder_b,
  input  logic [DATA_WIDTH-1:0]         adder_sum,
  input  logic                          adder_carry,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_sum,
  output logic                          rsp_carry,
  output logic                          busy
);

  // Handshake: a request transfers in any cycle where req_valid[i] && req_ready[i];
  // req_valid must stay high with stable operands until then. Responses have no
  // backpressure: rsp_valid is a one-cycle pulse the requester must take.

  logic [PTR_W-1:0]   ptr;
  logic               grant_any;
  logic [PTR_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant_oh;
  int                 scan_idx;

  logic [ADD_LATENCY-1:0] tag_valid;
  logic [PTR_W-1:0]       tag_idx [ADD_LATENCY];

  // Search from ptr upward with wrap; first pending requester wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    scan_idx  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = int'(ptr) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!grant_any && req_valid[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = PTR_W'(scan_idx);
      end
    end
    if (grant_any) grant_oh[grant_idx] = 1'b1;
  end

  assign req_ready = grant_oh;

  // Idle cycles drive zeros so the shared adder does not toggle.
  always_comb begin
    adder_a = '0;
    adder_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) begin
        adder_a = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        adder_b = req_b[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr <= '0;
    end else if (grant_any) begin
      if (grant_idx == PTR_W'(NUM_REQ - 1)) ptr <= '0;
      else                                  ptr <= grant_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tag_valid <= '0;
      for (int k = 0; k < ADD_LATENCY; k++) tag_idx[k] <= '0;
    end else begin
      tag_valid[0] <= grant_any;
      tag_idx[0]   <= grant_idx;
      for (int k = 1; k < ADD_LATENCY; k++) begin
        tag_valid[k] <= tag_valid[k-1];
        tag_idx[k]   <= tag_idx[k-1];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      rsp_valid[j] = tag_valid[ADD_LATENCY-1] && (tag_idx[ADD_LATENCY-1] == PTR_W'(j));
    end
  end

  assign rsp_sum   = adder_sum;
  assign rsp_carry = adder_carry;
  assign busy      = |tag_valid;

endmodule
